// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the 512-bit AES block scheduler.
package aes_sched_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WIDE_W = 512;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StOut
  } sched_state_e;

endpackage

// File: rtl/aes_lane_select.sv
// Combinational lane extraction: byte de-interleave of the wide data word and
// the matching 128-bit key slice for the selected lane.
module aes_lane_select
  import aes_sched_pkg::*;
(
  input  logic [0:WIDE_W-1] wide_data,
  input  logic [0:WIDE_W-1] wide_key,
  input  lane_idx_t         lane,
  output logic [0:BLK_W-1]  lane_data,
  output logic [0:BLK_W-1]  lane_key
);

  always_comb begin
    lane_data = '0;
    // Lane byte i is wide byte 4i+lane.
    for (int unsigned i = 0; i < BLK_W / 8; i++) begin
      lane_data[8*i +: 8] = wide_data[32*i + 8*32'(lane) +: 8];
    end
    lane_key = wide_key[32'(lane)*BLK_W +: BLK_W];
  end

endmodule

// File: rtl/aes_block_scheduler.sv
// Time-multiplexes one external AES-128 core over four byte-interleaved lanes.
// Optional WAIT watchdog with error reporting: define AES_SCHED_TIMEOUT_EN.
module aes_block_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:WIDE_W-1] in_data,
  input  logic [0:WIDE_W-1] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:WIDE_W-1] out_data,
  output logic              core_start,
  output logic [0:BLK_W-1]  core_data,
  output logic [0:BLK_W-1]  core_key,
  input  logic              core_done,
  input  logic [0:BLK_W-1]  core_result,
  output logic              busy,
  output logic              err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  sched_state_e      state_q, state_d;
  lane_idx_t         lane_q, lane_d;
  logic [0:WIDE_W-1] data_q, key_q, res_q;
  logic              accept, slot_we, timeout;

  // in_ready is gated by rst_n so it reads low while reset is asserted.
  assign in_ready = rst_n & (state_q == StIdle);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != StIdle);
  assign out_data = res_q;

  aes_lane_select u_lane_select (
    .wide_data (data_q),
    .wide_key  (key_q),
    .lane      (lane_q),
    .lane_data (core_data),
    .lane_key  (core_key)
  );

`ifdef AES_SCHED_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       err_q;

  assign timeout = (state_q == StWait) && (wdog_q == 8'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= (state_q == StWait) ? wdog_q + 8'd1 : 8'd0;
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout && !core_done) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    core_start = 1'b0;
    out_valid  = 1'b0;
    slot_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          lane_d  = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        core_start = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        if (core_done) begin
          slot_we = 1'b1;
          if (lane_q == lane_idx_t'(LANES - 1)) begin
            state_d = StOut;
          end else begin
            lane_d  = lane_q + 2'd1;
            state_d = StIssue;
          end
        end else if (timeout) begin
          state_d = StOut;
        end
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lane_q  <= '0;
      data_q  <= '0;
      key_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (accept) begin
        data_q <= in_data;
        key_q  <= in_key;
        res_q  <= '0;
      end else if (slot_we) begin
        res_q[32'(lane_q)*BLK_W +: BLK_W] <= core_result;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Directed bench for aes_block_scheduler with a fixed-latency core model.
module tb_aes_block_scheduler;

  localparam int unsigned CoreLat = 3;

  localparam logic [0:127] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [0:127] MapR0 = 128'h0004080c1014181c2024282c3034383c;
  localparam logic [0:127] MapR1 = 128'h0105090d1115191d2125292d3135393d;
  localparam logic [0:127] MapR2 = 128'h02060a0e12161a1e22262a2e32363a3e;
  localparam logic [0:127] MapR3 = 128'h03070b0f13171b1f23272b2f33373b3f;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:511] in_data;
  logic [0:511] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [0:511] out_data;
  logic         core_start;
  logic [0:127] core_data;
  logic [0:127] core_key;
  logic         core_done;
  logic [0:127] core_result;
  logic         busy;
  logic         err;

  logic         model_done = 1'b0;
  logic         stray_done;
  logic [0:127] model_res = '0;
  int           model_cnt = 0;
  int           resp_cnt = 0;
  int           resp_limit;

  int n_checks = 0;
  int n_pass   = 0;

  assign core_done   = model_done | stray_done;
  assign core_result = model_res;

  always #5 clk = ~clk;

  aes_block_scheduler #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_key      (in_key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_key    (core_key),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .err         (err)
  );

  // Core model: FIPS-197 answer for the known vector, data^key otherwise.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (core_start && resp_cnt < resp_limit) begin
      resp_cnt  <= resp_cnt + 1;
      model_res <= (core_data == FipsPt && core_key == FipsKey) ? FipsCt : core_data ^ core_key;
      if (CoreLat == 1) model_done <= 1'b1;
      else model_cnt <= CoreLat - 1;
    end else if (model_cnt != 0) begin
      if (model_cnt == 1) model_done <= 1'b1;
      model_cnt <= model_cnt - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from an IDLE cycle and wait (bounded) for out_valid.
  task automatic do_request(input logic [0:511] d, input logic [0:511] k,
                            output logic [0:511] res, output int cycles, output logic e);
    logic got = 1'b0;
    in_data  = d;
    in_key   = k;
    in_valid = 1'b1;
    cycles   = 0;
    res      = '0;
    e        = 1'b0;
    for (int n = 1; n <= 200 && !got; n++) begin
      tick();
      if (n == 1) in_valid = 1'b0;
      if (out_valid) begin
        got    = 1'b1;
        cycles = n;
        res    = out_data;
        e      = err;
      end
    end
    if (!got) check_eq("out_valid_wait", 1'b0, 1'b1);
  endtask

  initial begin
    logic [0:511] fips_data, fips_key, map_data, map_exp, res, saved;
    int           cyc, starts;
    logic         e, stable;

    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++) fips_data[8*(4*i+k) +: 8] = FipsPt[8*i +: 8];
    fips_key = {4{FipsKey}};
    for (int n = 0; n < 64; n++) map_data[8*n +: 8] = 8'(n);
    map_exp = {MapR0, MapR1, MapR2, MapR3};

    resp_limit = 1 << 30;
    stray_done = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_key     = '0;
    out_ready  = 1'b1;
    rst_n      = 1'b0;
    #2;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_core_start", core_start, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_out_data", out_data, 512'b0);
    check_eq("rst_core_data_key", {core_data, core_key}, 256'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1'b1);
    tick();

    // FIPS-197 vector on all four lanes.
    do_request(fips_data, fips_key, res, cyc, e);
    check_eq("fips_data", res, {4{FipsCt}});
    check_eq("fips_latency", 32'(cyc), 32'd17);
    check_eq("fips_err", e, 1'b0);
    tick();
    check_eq("fips_back_idle", in_ready, 1'b1);

    // Lane byte interleave with zero keys.
    do_request(map_data, '0, res, cyc, e);
    check_eq("map_data", res, map_exp);
    tick();

    // Stray core_done in IDLE.
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    check_eq("stray_busy", busy, 1'b0);
    check_eq("stray_in_ready", in_ready, 1'b1);
    check_eq("stray_out_data", out_data, map_exp);

    // Backpressure: hold out_ready low for 10 cycles.
    out_ready = 1'b0;
    do_request(fips_data, fips_key, res, cyc, e);
    saved  = res;
    stable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== saved || in_ready !== 1'b0) stable = 1'b0;
    end
    check_eq("bp_stable", stable, 1'b1);
    check_eq("bp_data", saved, {4{FipsCt}});
    out_ready = 1'b1;
    tick();
    check_eq("bp_release_in_ready", in_ready, 1'b1);
    check_eq("bp_release_out_valid", out_valid, 1'b0);

    // Reset during lane 2 WAIT; the pending core_done lands in IDLE.
    in_data  = map_data;
    in_key   = '0;
    in_valid = 1'b1;
    starts   = 0;
    for (int n = 1; n <= 100 && starts < 3; n++) begin
      tick();
      if (n == 1) in_valid = 1'b0;
      if (core_start) starts++;
    end
    check_eq("mid_starts", 32'(starts), 32'd3);
    tick();
    check_eq("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_in_ready", in_ready, 1'b0);
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_core_start", core_start, 1'b0);
    check_eq("mid_rst_out_data", out_data, 512'b0);
    check_eq("mid_rst_core_data_key", {core_data, core_key}, 256'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check_eq("late_done_busy", busy, 1'b0);
    check_eq("late_done_out_data", out_data, 512'b0);
    do_request(fips_data, fips_key, res, cyc, e);
    check_eq("after_rst_data", res, {4{FipsCt}});
    check_eq("after_rst_latency", 32'(cyc), 32'd17);
    tick();

`ifdef AES_SCHED_TIMEOUT_EN
    // Core answers lane 0 only; watchdog of 8 cycles aborts lane 1.
    resp_limit = resp_cnt + 1;
    do_request(map_data, '0, res, cyc, e);
    check_eq("to_err", e, 1'b1);
    check_eq("to_data", res, {MapR0, 384'b0});
    check_eq("to_latency", 32'(cyc), 32'd14);
    tick();
    resp_limit = 1 << 30;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_block_scheduler.md
# aes_block_scheduler

Sequences one shared AES-128 core over a 512-bit request, replacing four parallel AES-128 instances in the 512-bit encryption path. It accepts a 512-bit data word and a 512-bit key word over a valid/ready handshake and splits the data into four byte-interleaved 128-bit lanes. It issues the lanes to the core one at a time over a start/done handshake, collects the results, and returns the concatenated 512-bit ciphertext over a second valid/ready handshake.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before abort; used only with AES_SCHED_TIMEOUT_EN; legal range 2..255.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronised externally.
- in_valid  in  1  request valid.
- in_ready  out  1  scheduler can accept a request; high only in IDLE.
- in_data  in  [0:511]  plaintext, big-endian bit order (bit 0 = MSB).
- in_key  in  [0:511]  four 128-bit keys; lane k uses in_key[128k +: 128].
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_data  out  [0:511]  {r0,r1,r2,r3}, where rk is the lane-k core result.
- core_start  out  1  one-cycle pulse that launches the core.
- core_data  out  [0:128)  lane plaintext; stable from start until done.
- core_key  out  [0:127]  lane key; stable from start until done.
- core_done  in  1  one-cycle pulse; core_result is valid in the same cycle.
- core_result  in  [0:127]  lane ciphertext.
- busy  out  1  high in every state except IDLE.
- err  out  1  high with out_valid when the request was aborted; constant 0 without the macro.

## Operation
- Lane split: lane k byte i (i = 0..15) = in_data byte 4i+k, where byte n = in_data[8n +: 8].
- in_data and in_key are registered on acceptance (in_valid & in_ready). Inputs are don't-care afterwards.
- FSM states IDLE, ISSUE, WAIT, OUT, with a 2-bit lane counter.
  - IDLE: on accept, lane <= 0, clear err and the result register, go to ISSUE.
  - ISSUE: core_start = 1 for one cycle, then go to WAIT.
  - WAIT: on core_done, store core_result into slot rk.
    - If lane = 3, go to OUT.
    - Otherwise lane++ and go to ISSUE.
  - OUT: out_valid = 1. On out_ready, go to IDLE.
- core_data and core_key are combinational selects of the registered lane by the lane counter.
- core_done outside WAIT is ignored: no state change and no slot write.
- out_data and err hold stable while out_valid is high and not yet accepted.

## Timing
- Reset values:
  - Outputs: in_ready = 0 during reset and 1 in the first cycle after reset. out_valid = 0, core_start = 0, busy = 0, err = 0.
  - out_data, core_data and core_key reset to all zeros.
  - State resets to IDLE with lane = 0.
- Core latency L ≥ 1: core_done arrives L cycles after core_start.
- Accept at cycle 0 → lane 0 start at cycle 1 → out_valid at cycle 1 + 4(L+1). With L = 3, out_valid is at cycle 17.
- Back-to-back operation: acceptance in OUT is impossible. The next acceptance is one cycle after out_ready is seen.
- Reset mid-operation: return to IDLE immediately and discard partial results. A late core_done from the aborted operation is ignored because it does not arrive in WAIT.

## Configuration
- AES_SCHED_TIMEOUT_EN defined:
  - An 8-bit watchdog clears on entry to WAIT and counts every cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES without core_done, the scheduler sets err = 1 and goes to OUT.
  - Unfinished lanes read as zero; completed lanes keep their results.
- Not defined: WAIT is unbounded, err is tied 0, and there is no counter logic.

## Structure
- aes_sched_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/OUT);
  - the constants LANES = 4, BLK_W = 128 and WIDE_W = 512;
  - the lane index type.
- One sub-module, aes_lane_select: a combinational lane-k byte de-interleave plus key slice, with inputs wide data, wide key and lane, and outputs 128-bit data and key.
- The core itself is external; it is not instantiated here.

## Test plan
- FIPS-197 vector, core model L = 3:
  - Stimulus: in_key = 000102…0f repeated four times; in_data byte 4i+k = plaintext byte i of 00112233445566778899aabbccddeeff.
  - Required response: out_data = 69c4e0d86a7b0430d8cdb78070b4c55a repeated four times, out_valid at cycle 17, err = 0.
- Lane mapping: core model returns core_data XOR core_key, with keys 0 and in_data bytes = 00..3f → r0 bytes 00,04,…,3c; r1 bytes 01,05,…,3d; r3 bytes 03,07,…,3f.
- Backpressure: out_ready held low for 10 cycles → out_valid and out_data stable, in_ready = 0; out_ready pulse → IDLE the next cycle, in_ready = 1.
- Stray/reset: core_done pulsed in IDLE → no state change. rst_n low during lane 2 WAIT → all outputs reset; a late core_done is ignored; the next request produces a correct result.
- AES_SCHED_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and the core never answering lane 1 → out_valid with err = 1, out_data[128:511] = 0, r0 intact.
